// File: rtl/ext_obi_slave_cut.sv
// Registered OBI request/response cut between the external bus and the CGRA slave port.
// Breaks the combinational req->gnt and rvalid paths while keeping strict in-order completion.
package ext_obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_payload_t;
endpackage

module ext_obi_slave_cut
  import ext_obi_pkg::*;
#(
  parameter int  REQ_DEPTH       = 2,
  parameter int  MAX_OUTSTANDING = 4,
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  obi_req_t         mst_req_i,
  output obi_resp_t        mst_resp_o,
  output obi_req_t         slv_req_o,
  input  obi_resp_t        slv_resp_i,
  output logic [OUT_W-1:0] outstanding_o,
  output logic             idle_o
);

  localparam int PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(REQ_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(REQ_DEPTH);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(REQ_DEPTH - 1);

  obi_payload_t     mem [REQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [OUT_W-1:0] outstanding_q;
  logic             rvalid_q;
  logic [31:0]      rdata_q;

  logic             fifo_empty, fifo_full;
  logic             mst_gnt, push, pop, capture;
  obi_payload_t     head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);

  // Grant looks only at registered occupancy: a same-cycle slave pop never frees a slot early.
  assign mst_gnt = mst_req_i.req & ~fifo_full & (outstanding_q < MAX_OUT_C);
  assign push    = mst_gnt;
  assign pop     = ~fifo_empty & slv_resp_i.gnt;

  // Only capture a slave response when one is actually owed, so stale rvalids after reset are dropped.
  assign capture = slv_resp_i.rvalid & (outstanding_q > OUT_W'(rvalid_q));

  assign head = fifo_empty ? '0 : mem[rd_ptr_q];

  // NOTE: payload storage is not reset; the empty-FIFO mux above keeps it invisible until written.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= '{we: mst_req_i.we, be: mst_req_i.be,
                         addr: mst_req_i.addr, wdata: mst_req_i.wdata};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;

      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      case ({push, rvalid_q})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase

      rvalid_q <= capture;
      rdata_q  <= capture ? slv_resp_i.rdata : '0;
    end
  end

  // NOTE: every output gets a default first so no path through this block can infer a latch.
  always_comb begin
    slv_req_o       = '0;
    slv_req_o.req   = ~fifo_empty;
    slv_req_o.we    = head.we;
    slv_req_o.be    = head.be;
    slv_req_o.addr  = head.addr;
    slv_req_o.wdata = head.wdata;

    mst_resp_o        = '0;
    mst_resp_o.gnt    = mst_gnt;
    mst_resp_o.rvalid = rvalid_q;
    mst_resp_o.rdata  = rdata_q;
  end

  assign outstanding_o = outstanding_q;
  assign idle_o        = fifo_empty & (outstanding_q == '0) & ~rvalid_q;

  a_slv_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (slv_req_o.req && !slv_resp_i.gnt) |=> (slv_req_o.req && $stable(head)));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_q |-> (outstanding_q != '0));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && fifo_full));

endmodule

// File: tb/tb_ext_obi_slave_cut.sv
// Bench for ext_obi_slave_cut: queue-level reference model compared every cycle, plus
// hand-derived timing/order expectations for the directed scenarios.
module tb_ext_obi_slave_cut;
  import ext_obi_pkg::*;

  localparam int REQ_DEPTH = 2;
  localparam int MAX_OUT   = 4;
  localparam int HN        = 2048;

  logic        clk_i, rst_ni;
  obi_req_t    mst_req, slv_req;
  obi_resp_t   mst_resp, slv_resp;
  logic [2:0]  outstanding;
  logic        idle;

  logic        slv_gnt, slv_rvalid;
  logic [31:0] slv_rdata;
  int          rsp_delay;
  assign slv_resp = {slv_gnt, slv_rvalid, slv_rdata};

  ext_obi_slave_cut #(.REQ_DEPTH(REQ_DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mst_req_i(mst_req), .mst_resp_o(mst_resp),
    .slv_req_o(slv_req), .slv_resp_i(slv_resp),
    .outstanding_o(outstanding), .idle_o(idle)
  );

  int checks = 0, errors = 0, cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  initial begin clk_i = 1'b0; forever #5 clk_i = ~clk_i; end
  initial forever @(posedge clk_i) cyc++;

  // Per-cycle history and event logs (sampled at negedge).
  logic        h_gnt [HN], h_req [HN], h_slvreq [HN], h_rvalid [HN], h_idle [HN];
  logic [31:0] h_addr [HN], h_out [HN];
  int          acc_cyc[$], sp_cyc[$], rv_cyc[$];
  logic [31:0] rv_data[$];

  // Master driver: holds each request until granted.
  obi_req_t mq[$];
  bit       drv_hs;
  initial begin
    mst_req = '0;
    forever begin
      @(negedge clk_i);
      drv_hs = rst_ni && mst_req.req && mst_resp.gnt;
      @(posedge clk_i); #1;
      if (!rst_ni) begin
        mq.delete();
        mst_req = '0;
      end else begin
        if (drv_hs) void'(mq.pop_front());
        mst_req = (mq.size() > 0) ? mq[0] : '0;
      end
    end
  end

  // In-order slave: responds rsp_delay cycles after each handshake.
  typedef struct { logic [31:0] data; int due; } rsp_t;
  rsp_t sq[$];
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni && slv_req.req && slv_gnt)
        sq.push_back('{data: slv_req.we ? 32'h0 : slv_req.addr, due: cyc + rsp_delay});
    end
  end
  initial begin
    slv_rvalid = 1'b0; slv_rdata = 32'h5A5A_5A5A;
    forever begin
      @(posedge clk_i); #1;
      if (!rst_ni) begin
        sq.delete();
        slv_rvalid = 1'b0; slv_rdata = 32'h5A5A_5A5A;
      end else if (sq.size() > 0 && sq[0].due <= cyc) begin
        slv_rvalid = 1'b1; slv_rdata = sq[0].data;
        void'(sq.pop_front());
      end else begin
        slv_rvalid = 1'b0; slv_rdata = 32'h5A5A_5A5A;
      end
    end
  end

  // Reference model: request queue, acceptance-order expected data, outstanding count.
  obi_req_t    m_fifo[$];
  logic [31:0] m_order[$];
  int          m_out;
  bit          m_rv, e_gnt, m_hs, m_pop;
  logic [31:0] e_addr, e_wdata, e_web, e_rdata;
  initial begin
    m_out = 0; m_rv = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        m_fifo.delete(); m_order.delete(); m_out = 0; m_rv = 0;
        continue;
      end
      e_gnt   = mst_req.req && (m_fifo.size() < REQ_DEPTH) && (m_out < MAX_OUT);
      e_addr  = (m_fifo.size() > 0) ? m_fifo[0].addr  : 32'h0;
      e_wdata = (m_fifo.size() > 0) ? m_fifo[0].wdata : 32'h0;
      e_web   = (m_fifo.size() > 0) ? {27'h0, m_fifo[0].we, m_fifo[0].be} : 32'h0;
      e_rdata = (m_rv && m_order.size() > 0) ? m_order[0] : 32'h0;
      check("gnt",         mst_resp.gnt, e_gnt);
      check("slv_req",     slv_req.req, m_fifo.size() > 0);
      check("slv_addr",    slv_req.addr, e_addr);
      check("slv_wdata",   slv_req.wdata, e_wdata);
      check("slv_we_be",   {27'h0, slv_req.we, slv_req.be}, e_web);
      check("rvalid",      mst_resp.rvalid, m_rv);
      check("rdata",       mst_resp.rdata, e_rdata);
      check("outstanding", outstanding, m_out);
      check("idle",        idle, (m_fifo.size() == 0) && (m_out == 0) && !m_rv);

      if (cyc < HN) begin
        h_gnt[cyc] = mst_resp.gnt;     h_req[cyc]    = mst_req.req;
        h_slvreq[cyc] = slv_req.req;   h_rvalid[cyc] = mst_resp.rvalid;
        h_idle[cyc] = idle;            h_addr[cyc]   = slv_req.addr;
        h_out[cyc] = 32'(outstanding);
      end
      if (mst_req.req && mst_resp.gnt) acc_cyc.push_back(cyc);
      if (slv_req.req && slv_gnt)      sp_cyc.push_back(cyc);
      if (mst_resp.rvalid) begin rv_cyc.push_back(cyc); rv_data.push_back(mst_resp.rdata); end

      m_hs  = mst_req.req && e_gnt;
      m_pop = (m_fifo.size() > 0) && slv_gnt;
      if (m_rv) begin void'(m_order.pop_front()); m_out--; end
      if (m_pop) void'(m_fifo.pop_front());
      if (m_hs) begin
        m_fifo.push_back(mst_req);
        m_order.push_back(mst_req.we ? 32'h0 : mst_req.addr);
        m_out++;
      end
      m_rv = slv_rvalid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic push_rd(input logic [31:0] a);
    obi_req_t r = '0;
    r.req = 1'b1; r.be = 4'hF; r.addr = a;
    mq.push_back(r);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    obi_req_t r = '0;
    r.req = 1'b1; r.we = 1'b1; r.be = 4'hF; r.addr = a; r.wdata = d;
    mq.push_back(r);
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk_i);
      if (idle && mq.size() == 0 && !mst_req.req && sq.size() == 0 && !slv_rvalid) done = 1'b1;
    end
    check("drain_within_budget", done, 1);
    tick(1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_gnt"},    mst_resp.gnt, 0);
    check({tag, "_rvalid"}, mst_resp.rvalid, 0);
    check({tag, "_rdata"},  mst_resp.rdata, 0);
    check({tag, "_slvreq"}, slv_req.req, 0);
    check({tag, "_addr"},   slv_req.addr, 0);
    check({tag, "_wdata"},  slv_req.wdata, 0);
    check({tag, "_we_be"},  {27'h0, slv_req.we, slv_req.be}, 0);
    check({tag, "_out"},    outstanding, 0);
    check({tag, "_idle"},   idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int a, b, r, s, f, p, bad, pk, n;
  initial begin
    rst_ni = 1'b0; slv_gnt = 1'b0; rsp_delay = 1;
    #1;
    check_reset_values("reset");
    tick(3);
    rst_ni = 1'b1;
    tick(2);

    // Single write: gnt in request cycle, slave req +1, rvalid +3, idle +4.
    slv_gnt = 1'b1; rsp_delay = 1; b = acc_cyc.size();
    push_wr(32'hF000_0000, 32'hDEAD_BEEF);
    wait_idle(50);
    a = acc_cyc[b];
    check("t1_req_first_cycle", h_req[a-1], 0);
    check("t1_slvreq_not_same", h_slvreq[a], 0);
    check("t1_slvreq_next",     h_slvreq[a+1], 1);
    check("t1_rvalid_early",    h_rvalid[a+2], 0);
    check("t1_rvalid_at3",      h_rvalid[a+3], 1);
    check("t1_out_at3",         h_out[a+3], 1);
    check("t1_out_at4",         h_out[a+4], 0);
    check("t1_idle_at4",        h_idle[a+4], 1);

    // Back-to-back reads into a stalled slave; also full FIFO + pop in the same cycle.
    slv_gnt = 1'b0; rsp_delay = 1;
    b = acc_cyc.size(); r = rv_data.size(); s = sp_cyc.size();
    for (int i = 0; i < 4; i++) push_rd(32'(4 * i));
    tick(6);
    slv_gnt = 1'b1;
    wait_idle(100);
    a = acc_cyc[b];
    check("t2_second_accept", acc_cyc[b+1], a + 1);
    check("t2_third_accept",  acc_cyc[b+2], a + 6);
    bad = 0;
    for (int k = a + 2; k <= a + 4; k++)
      if (h_gnt[k] !== 1'b0 || h_slvreq[k] !== 1'b1 || h_addr[k] !== 32'h0) bad++;
    check("t2_stall_hold", bad, 0);
    check("t2_rv_count", rv_data.size() - r, 4);
    for (int i = 0; i < 4; i++) check("t2_rdata_order", rv_data[r+i], 32'(4 * i));
    p = sp_cyc[s];
    check("t5_first_pop_cycle", p, a + 5);
    check("t5_gnt_full_pop",    h_gnt[p], 0);
    check("t5_gnt_next",        h_gnt[p+1], 1);

    // Outstanding limit with slow responses.
    slv_gnt = 1'b1; rsp_delay = 10; b = acc_cyc.size(); r = rv_cyc.size();
    for (int i = 0; i < 6; i++) push_rd(32'h100 + 32'(4 * i));
    wait_idle(200);
    f = rv_cyc[r];
    n = 0;
    for (int i = b; i < acc_cyc.size(); i++) if (acc_cyc[i] < f) n++;
    check("t3_accepts_before_rv", n, 4);
    bad = 0;
    for (int k = acc_cyc[b+3] + 1; k <= f; k++) if (h_gnt[k] !== 1'b0) bad++;
    check("t3_gnt_blocked", bad, 0);
    pk = 0;
    for (int k = acc_cyc[b]; k <= f; k++) if (int'(h_out[k]) > pk) pk = int'(h_out[k]);
    check("t3_peak_out", pk, 4);
    check("t3_rv_count", rv_cyc.size() - r, 6);

    // Steady streaming: accept and response on the same edge, push and pop on the same edge.
    slv_gnt = 1'b1; rsp_delay = 1; b = acc_cyc.size();
    for (int i = 0; i < 6; i++) push_rd(32'h200 + 32'(4 * i));
    wait_idle(100);
    a = acc_cyc[b];
    check("t4_fifth_accept", acc_cyc[b+4], a + 4);
    check("t4_rvalid_with_accept", h_rvalid[a+4], 1);
    check("t4_out_a4", h_out[a+4], 3);
    check("t4_out_a5", h_out[a+5], 3);
    bad = 0;
    for (int k = a + 1; k <= a + 6; k++) if (h_slvreq[k] !== 1'b1) bad++;
    check("t4_fifo_steady", bad, 0);

    // Reset with one transaction at the slave and two queued.
    slv_gnt = 1'b1; rsp_delay = 40;
    push_rd(32'h300);
    tick(4);
    slv_gnt = 1'b0;
    push_rd(32'h304); push_rd(32'h308);
    tick(5);
    check("t6_pre_out",    outstanding, 3);
    check("t6_pre_slvreq", slv_req.req, 1);
    rst_ni = 1'b0; mq.delete(); mst_req = '0;
    #1;
    check_reset_values("t6_reset");
    tick(3);
    rst_ni = 1'b1; slv_gnt = 1'b1;
    r = rv_cyc.size();
    tick(50);
    check("t6_no_rvalid_after_reset", rv_cyc.size() - r, 0);
    rsp_delay = 1; b = acc_cyc.size(); r = rv_data.size();
    push_wr(32'h400, 32'h1234_5678);
    wait_idle(50);
    check("t6_fresh_accept", acc_cyc.size() - b, 1);
    check("t6_fresh_rvalid", rv_data.size() - r, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
